// File: rtl/exe0_token_arbiter.sv
// Weighted round-robin arbiter sharing one Exe0 stage between two Dec0 token lanes.
// Accepted tokens go through a 2-entry FIFO tagged with their source lane; drain/idle quiesces Exe0.
module exe0_token_arbiter #(
   parameter int PW = 130,
   parameter int W0 = 2,
   parameter int W1 = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s0_valid,
   output logic          s0_ready,
   input  logic [PW-1:0] s0_data,
   input  logic          s1_valid,
   output logic          s1_ready,
   input  logic [PW-1:0] s1_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [PW-1:0] m_data,
   output logic          m_src,
   input  logic          drain,
   output logic          idle,
   output logic [15:0]   cnt0,
   output logic [15:0]   cnt1
);

   localparam logic [3:0] W0_LAST = 4'(W0 - 1);
   localparam logic [3:0] W1_LAST = 4'(W1 - 1);

   typedef enum logic {
      TURN_L0 = 1'b0,
      TURN_L1 = 1'b1
   } turn_t;

   turn_t         turn_r;
   turn_t         turn_next_s;
   logic [3:0]    bcnt_r;
   logic [3:0]    bcnt_next_s;
   logic [1:0]    count_r;
   logic [1:0]    count_next_s;
   logic [PW-1:0] head_data_r;
   logic          head_src_r;
   logic [PW-1:0] tail_data_r;
   logic          tail_src_r;
   logic [15:0]   cnt0_r;
   logic [15:0]   cnt1_r;

   logic          grant_en_s;
   logic          grant0_s;
   logic          grant1_s;
   logic          push_s;
   logic          pop_s;
   logic          push_src_s;
   logic [PW-1:0] push_data_s;

   // Grant selection; readies are held low while reset is asserted.
   always_comb begin
      grant_en_s = 1'b0;
      grant0_s   = 1'b0;
      grant1_s   = 1'b0;
      if (rst && (count_r != 2'd2) && !drain) begin
         grant_en_s = 1'b1;
      end else begin
         grant_en_s = 1'b0;
      end
      if (grant_en_s) begin
         if (s0_valid && s1_valid) begin
            grant0_s = (turn_r == TURN_L0);
            grant1_s = (turn_r == TURN_L1);
         end else begin
            grant0_s = s0_valid;
            grant1_s = s1_valid;
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Turn/burst next state: only a grant to the turn lane advances the burst.
   always_comb begin
      turn_next_s = turn_r;
      bcnt_next_s = bcnt_r;
      case (turn_r)
         TURN_L0: begin
            if (grant0_s) begin
               if (bcnt_r == W0_LAST) begin
                  turn_next_s = TURN_L1;
                  bcnt_next_s = 4'd0;
               end else begin
                  bcnt_next_s = bcnt_r + 4'd1;
               end
            end else begin
               bcnt_next_s = bcnt_r;
            end
         end
         TURN_L1: begin
            if (grant1_s) begin
               if (bcnt_r == W1_LAST) begin
                  turn_next_s = TURN_L0;
                  bcnt_next_s = 4'd0;
               end else begin
                  bcnt_next_s = bcnt_r + 4'd1;
               end
            end else begin
               bcnt_next_s = bcnt_r;
            end
         end
         default: begin
            turn_next_s = TURN_L0;
            bcnt_next_s = 4'd0;
         end
      endcase
   end

   // Arbiter state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         turn_r <= TURN_L0;
         bcnt_r <= 4'd0;
      end else begin
         turn_r <= turn_next_s;
         bcnt_r <= bcnt_next_s;
      end
   end

   // FIFO push/pop decode and occupancy next value.
   always_comb begin
      push_s       = grant0_s | grant1_s;
      push_src_s   = grant1_s;
      push_data_s  = grant1_s ? s1_data : s0_data;
      pop_s        = (count_r != 2'd0) && m_ready;
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + 2'd1;
         2'b01:   count_next_s = count_r - 2'd1;
         default: count_next_s = count_r;
      endcase
   end

   // Two-entry FIFO as head/tail registers; head only loads a push when it would otherwise be empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_r     <= 2'd0;
         head_data_r <= {PW{1'b0}};
         head_src_r  <= 1'b0;
         tail_data_r <= {PW{1'b0}};
         tail_src_r  <= 1'b0;
      end else begin
         count_r <= count_next_s;
         if (pop_s && (count_r == 2'd2)) begin
            head_data_r <= tail_data_r;
            head_src_r  <= tail_src_r;
         end else if (push_s && ((count_r == 2'd0) || (pop_s && (count_r == 2'd1)))) begin
            head_data_r <= push_data_s;
            head_src_r  <= push_src_s;
         end
         if (push_s && !pop_s && (count_r == 2'd1)) begin
            tail_data_r <= push_data_s;
            tail_src_r  <= push_src_s;
         end
      end
   end

   // Per-lane accepted-token counters, wrapping at 16 bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt0_r <= 16'd0;
         cnt1_r <= 16'd0;
      end else begin
         if (grant0_s) begin
            cnt0_r <= cnt0_r + 16'd1;
         end
         if (grant1_s) begin
            cnt1_r <= cnt1_r + 16'd1;
         end
      end
   end

   assign s0_ready = grant0_s;
   assign s1_ready = grant1_s;
   assign m_valid  = (count_r != 2'd0);
   assign m_data   = head_data_r;
   assign m_src    = head_src_r;
   assign idle     = drain && (count_r == 2'd0);
   assign cnt0     = cnt0_r;
   assign cnt1     = cnt1_r;

endmodule

// File: tb/tb_exe0_token_arbiter.sv
// Self-checking bench for exe0_token_arbiter: a directed vector table plus hand sequences,
// with a reference arbiter model and a FIFO scoreboard checking every cycle.
module tb_exe0_token_arbiter;

   localparam int PW = 130;
   localparam int W0 = 2;
   localparam int W1 = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          s0_valid, s1_valid, s0_ready, s1_ready;
   logic [PW-1:0] s0_data, s1_data, m_data;
   logic          m_valid, m_ready, m_src, drain, idle;
   logic [15:0]   cnt0, cnt1;

   exe0_token_arbiter #(.PW(PW), .W0(W0), .W1(W1)) dut (
      .clk(clk), .rst(rst),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_src(m_src),
      .drain(drain), .idle(idle), .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          src;
      logic [PW-1:0] data;
   } tok_t;

   typedef struct {
      logic v0, v1, mr, dr;
      logic e_r0, e_r1, e_mv, e_idle;
   } vec_t;

   tok_t       sb_q[$];
   vec_t       vecs[14];
   int         total = 0;
   int         bad   = 0;

   int         md_count;
   logic       md_turn;
   logic [3:0] md_bcnt;
   logic [15:0] md_cnt0, md_cnt1;

   function automatic logic [PW-1:0] rand_tok();
      logic [1:0] top;
      top = 2'($urandom());
      return {top, $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      md_count = 0;
      md_turn  = 1'b0;
      md_bcnt  = 4'd0;
      md_cnt0  = 16'd0;
      md_cnt1  = 16'd0;
      sb_q.delete();
   endtask

   // One clock cycle: drive, check against the model at the negedge, advance the model, step the edge.
   task automatic cycle(input logic v0, input logic v1, input logic mr, input logic dr,
                        input logic [PW-1:0] d0, input logic [PW-1:0] d1,
                        output logic o_r0, output logic o_r1, output logic o_mv,
                        output logic o_idle, output logic [PW-1:0] o_md);
      logic en, g0, g1, pop;
      tok_t t;
      s0_valid = v0; s1_valid = v1; m_ready = mr; drain = dr;
      s0_data = d0; s1_data = d1;
      @(negedge clk);
      o_r0 = s0_ready; o_r1 = s1_ready; o_mv = m_valid; o_idle = idle; o_md = m_data;
      en  = (md_count < 2) && !dr;
      g0  = en && v0 && (!v1 || (md_turn == 1'b0));
      g1  = en && v1 && (!v0 || (md_turn == 1'b1));
      pop = (md_count != 0) && mr;
      chk("s0_ready", s0_ready, g0);
      chk("s1_ready", s1_ready, g1);
      chk("m_valid", m_valid, md_count != 0);
      chk("idle", idle, dr && (md_count == 0));
      chk("cnt0", cnt0, md_cnt0);
      chk("cnt1", cnt1, md_cnt1);
      if (md_count != 0) begin
         if (sb_q.size() == 0) begin
            chk("sb_nonempty", 1'b0, 1'b1);
         end else begin
            chk("m_data", m_data, sb_q[0].data);
            chk("m_src", m_src, sb_q[0].src);
            if (pop) void'(sb_q.pop_front());
         end
      end
      if (g0 || g1) begin
         t.src  = g1;
         t.data = g1 ? d1 : d0;
         sb_q.push_back(t);
         if (g1 == md_turn) begin
            if (md_bcnt == (g1 ? 4'(W1 - 1) : 4'(W0 - 1))) begin
               md_turn = ~g1;
               md_bcnt = 4'd0;
            end else begin
               md_bcnt = md_bcnt + 4'd1;
            end
         end
      end
      if (g0) md_cnt0 = md_cnt0 + 16'd1;
      if (g1) md_cnt1 = md_cnt1 + 16'd1;
      md_count = md_count + ((g0 || g1) ? 1 : 0) - (pop ? 1 : 0);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic v0, input logic v1, input logic mr, input logic dr);
      logic a, b, c, d;
      logic [PW-1:0] e;
      cycle(v0, v1, mr, dr, rand_tok(), rand_tok(), a, b, c, d, e);
   endtask

   initial begin
      logic r0, r1, mv, id;
      logic [PW-1:0] md, tok_a, tok_b, tok_c;
      logic [15:0] base0, base1;
      int guard;

      // Starting from reset: weighted grants, backpressure to full, lane-1-only, drain and resume.
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0};

      // Reset held with both lanes requesting.
      rst = 1'b0; s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b0; drain = 1'b0;
      s0_data = rand_tok(); s1_data = rand_tok();
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_s0_ready", s0_ready, 1'b0);
      chk("rst_s1_ready", s1_ready, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_cnt0", cnt0, 16'd0);
      chk("rst_cnt1", cnt1, 16'd0);
      chk("rst_m_src", m_src, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;

      for (int i = 0; i < 14; i++) begin
         cycle(vecs[i].v0, vecs[i].v1, vecs[i].mr, vecs[i].dr, rand_tok(), rand_tok(), r0, r1, mv, id, md);
         chk($sformatf("vec%0d_s0_ready", i), r0, vecs[i].e_r0);
         chk($sformatf("vec%0d_s1_ready", i), r1, vecs[i].e_r1);
         chk($sformatf("vec%0d_m_valid", i), mv, vecs[i].e_mv);
         chk($sformatf("vec%0d_idle", i), id, vecs[i].e_idle);
      end

      // Weighted fairness: 30 grants in the pattern 0,0,1.
      base0 = md_cnt0; base1 = md_cnt1;
      for (int i = 0; i < 30; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 1'b0, rand_tok(), rand_tok(), r0, r1, mv, id, md);
         chk($sformatf("fair%0d_s0_ready", i), r0, (i % 3) != 2);
         chk($sformatf("fair%0d_s1_ready", i), r1, (i % 3) == 2);
      end
      chk("fair_cnt0_delta", 16'(cnt0 - base0), 16'd20);
      chk("fair_cnt1_delta", 16'(cnt1 - base1), 16'd10);
      repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);

      // Backpressure: A, B accepted, C held until a pop registers.
      tok_a = rand_tok(); tok_b = rand_tok(); tok_c = rand_tok();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, tok_a, rand_tok(), r0, r1, mv, id, md);
      chk("bp_a_ready", r0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, tok_b, rand_tok(), r0, r1, mv, id, md);
      chk("bp_b_ready", r0, 1'b1);
      chk("bp_head_a1", md, tok_a);
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0, tok_c, rand_tok(), r0, r1, mv, id, md);
         chk("bp_c_held", r0, 1'b0);
         chk("bp_head_a2", md, tok_a);
      end
      cycle(1'b1, 1'b0, 1'b1, 1'b0, tok_c, rand_tok(), r0, r1, mv, id, md);
      chk("bp_pop_cycle_ready", r0, 1'b0);
      chk("bp_pop_head", md, tok_a);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, tok_c, rand_tok(), r0, r1, mv, id, md);
      chk("bp_c_accepted", r0, 1'b1);
      chk("bp_head_b", md, tok_b);
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);

      // Single requester on lane 1, then both lanes resume from the preserved turn.
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 1'b0, rand_tok(), rand_tok(), r0, r1, mv, id, md);
         chk($sformatf("single%0d_s1_ready", i), r1, 1'b1);
      end
      repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0);

      // Reset mid-transfer discards the FIFO and drops readies immediately.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      s0_valid = 1'b1; s1_valid = 1'b1;
      rst = 1'b0;
      #1;
      chk("midrst_s0_ready", s0_ready, 1'b0);
      chk("midrst_s1_ready", s1_ready, 1'b0);
      chk("midrst_m_valid", m_valid, 1'b0);
      chk("midrst_cnt0", cnt0, 16'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;

      // Counter wrap on lane 0.
      base1 = md_cnt1;
      guard = 0;
      while ((md_cnt0 != 16'hFFFF) && (guard < 70000)) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         guard++;
      end
      chk("wrap_reached", cnt0, 16'hFFFF);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("wrap_cnt0", cnt0, 16'h0000);
      chk("wrap_cnt1", cnt1, base1);
      repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
